// File: rtl/streamer_traffic_checker.sv
// Streamer traffic generator/checker: emits an incrementing word sequence on TX,
// tracks sequence continuity on RX, and keeps saturating traffic/latency statistics.
module streamer_traffic_checker #(
  parameter int g_data_width = 64,
  parameter int g_lat_width  = 28,
  parameter int g_cnt_width  = 32
) (
  input  logic                      clk_sys_i,
  input  logic                      rst_i,
  input  logic                      cfg_enable_i,
  input  logic                      cfg_clear_i,
  input  logic [7:0]                cfg_tx_rate_i,
  input  logic [7:0]                cfg_rx_rate_i,
  output logic [g_data_width-1:0]   tx_data_o,
  output logic                      tx_valid_o,
  input  logic                      tx_dreq_i,
  input  logic [g_data_width-1:0]   rx_data_i,
  input  logic                      rx_valid_i,
  input  logic                      rx_lost_i,
  output logic                      rx_dreq_o,
  input  logic [g_lat_width-1:0]    rx_latency_i,
  input  logic                      rx_latency_valid_i,
  output logic [g_cnt_width-1:0]    tx_cnt_o,
  output logic [g_cnt_width-1:0]    rx_cnt_o,
  output logic [g_cnt_width-1:0]    err_cnt_o,
  output logic [g_cnt_width-1:0]    lost_cnt_o,
  output logic [g_cnt_width-1:0]    lat_cnt_o,
  output logic [g_lat_width-1:0]    lat_min_o,
  output logic [g_lat_width-1:0]    lat_max_o,
  output logic [g_lat_width+15:0]   lat_sum_o,
  output logic                      synced_o
);
  localparam int SW = g_lat_width + 16;
  localparam logic [g_data_width-1:0] DONE = 1;
  localparam logic [g_cnt_width-1:0]  CONE = 1;

  typedef enum logic {SYNC, TRACK} state_t;
  state_t state_q, state_d;

  logic [15:0]             lfsr;
  logic [g_data_width-1:0] tx_seq, expected_q, expected_d;
  logic                    tx_go, rx_inc, err_inc;
  logic [SW:0]             sum_w;

  function automatic logic [g_cnt_width-1:0] sat_inc(input logic [g_cnt_width-1:0] v);
    return (&v) ? v : v + CONE;
  endfunction

  // Free-running throttle source; taps 16,14,13,11.
  always_ff @(posedge clk_sys_i) begin
    if (rst_i) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign tx_go = cfg_enable_i & tx_dreq_i & ((cfg_tx_rate_i == 8'hFF) | (lfsr[7:0] < cfg_tx_rate_i));

  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      tx_seq     <= '0;
      tx_data_o  <= '0;
      tx_valid_o <= 1'b0;
      rx_dreq_o  <= 1'b0;
    end else begin
      tx_valid_o <= tx_go;
      if (tx_go) begin
        tx_data_o <= tx_seq;
        tx_seq    <= tx_seq + DONE;
      end
      rx_dreq_o <= cfg_enable_i & ((cfg_rx_rate_i == 8'hFF) | (lfsr[15:8] < cfg_rx_rate_i));
    end
  end

  // A lost frame drops back to SYNC, but a word arriving alongside it re-locks at once.
  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    rx_inc     = 1'b0;
    err_inc    = 1'b0;
    if (!cfg_enable_i) begin
      state_d = SYNC;
    end else if (rx_valid_i) begin
      rx_inc     = 1'b1;
      expected_d = rx_data_i + DONE;
      state_d    = TRACK;
      if (state_q == TRACK && !rx_lost_i && rx_data_i != expected_q) err_inc = 1'b1;
    end else if (rx_lost_i) begin
      state_d = SYNC;
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      state_q    <= SYNC;
      expected_q <= '0;
      synced_o   <= 1'b0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      synced_o   <= (state_d == TRACK);
    end
  end

  assign sum_w = {1'b0, lat_sum_o} + {{(SW - g_lat_width + 1){1'b0}}, rx_latency_i};

  // Clear behaves like reset for statistics only and overrides any same-cycle event.
  always_ff @(posedge clk_sys_i) begin
    if (rst_i || cfg_clear_i) begin
      tx_cnt_o   <= '0;
      rx_cnt_o   <= '0;
      err_cnt_o  <= '0;
      lost_cnt_o <= '0;
      lat_cnt_o  <= '0;
      lat_sum_o  <= '0;
      lat_min_o  <= '1;
      lat_max_o  <= '0;
    end else begin
      if (tx_go)     tx_cnt_o   <= sat_inc(tx_cnt_o);
      if (rx_inc)    rx_cnt_o   <= sat_inc(rx_cnt_o);
      if (err_inc)   err_cnt_o  <= sat_inc(err_cnt_o);
      if (rx_lost_i) lost_cnt_o <= sat_inc(lost_cnt_o);
      if (rx_latency_valid_i) begin
        lat_cnt_o <= sat_inc(lat_cnt_o);
        lat_sum_o <= sum_w[SW] ? '1 : sum_w[SW-1:0];
        if (rx_latency_i < lat_min_o) lat_min_o <= rx_latency_i;
        if (rx_latency_i > lat_max_o) lat_max_o <= rx_latency_i;
      end
    end
  end
endmodule

// File: tb/tb_streamer_traffic_checker.sv
// Directed bench: TX words tracked via scoreboard queue, RX/latency stats checked with assertions.
module tb_streamer_traffic_checker;
  localparam int DW = 64, LW = 28, CW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, clr, tx_dreq, loop, m_rx_valid, rx_lost, lat_v;
  logic [7:0]    txr, rxr;
  logic [DW-1:0] m_rx_data, rx_data, tx_data;
  logic          rx_valid, tx_valid, rx_dreq, synced;
  logic [LW-1:0] lat, lat_min, lat_max;
  logic [LW+15:0] lat_sum;
  logic [CW-1:0] tx_cnt, rx_cnt, err_cnt, lost_cnt, lat_cnt;

  assign rx_valid = loop ? tx_valid : m_rx_valid;
  assign rx_data  = loop ? tx_data  : m_rx_data;

  streamer_traffic_checker u_dut (
    .clk_sys_i(clk), .rst_i(rst), .cfg_enable_i(en), .cfg_clear_i(clr),
    .cfg_tx_rate_i(txr), .cfg_rx_rate_i(rxr),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_dreq_i(tx_dreq),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_lost_i(rx_lost), .rx_dreq_o(rx_dreq),
    .rx_latency_i(lat), .rx_latency_valid_i(lat_v),
    .tx_cnt_o(tx_cnt), .rx_cnt_o(rx_cnt), .err_cnt_o(err_cnt), .lost_cnt_o(lost_cnt),
    .lat_cnt_o(lat_cnt), .lat_min_o(lat_min), .lat_max_o(lat_max), .lat_sum_o(lat_sum),
    .synced_o(synced));

  // Narrow instance for sequence wrap and counter saturation.
  logic        s_en, s_dreq, s_loop, s_m_valid, s_rx_valid, s_tx_valid, s_rx_dreq, s_synced;
  logic [7:0]  s_m_data, s_rx_data, s_tx_data;
  logic [3:0]  s_tx_cnt, s_rx_cnt, s_err_cnt, s_lost_cnt, s_lat_cnt;
  logic [LW-1:0] s_lat_min, s_lat_max;
  logic [LW+15:0] s_lat_sum;
  logic [LW-1:0] s_lat;
  logic        s_lat_v, s_lost;

  assign s_rx_valid = s_loop ? s_tx_valid : s_m_valid;
  assign s_rx_data  = s_loop ? s_tx_data  : s_m_data;

  streamer_traffic_checker #(.g_data_width(8), .g_lat_width(LW), .g_cnt_width(4)) u_small (
    .clk_sys_i(clk), .rst_i(rst), .cfg_enable_i(s_en), .cfg_clear_i(clr),
    .cfg_tx_rate_i(txr), .cfg_rx_rate_i(rxr),
    .tx_data_o(s_tx_data), .tx_valid_o(s_tx_valid), .tx_dreq_i(s_dreq),
    .rx_data_i(s_rx_data), .rx_valid_i(s_rx_valid), .rx_lost_i(s_lost), .rx_dreq_o(s_rx_dreq),
    .rx_latency_i(s_lat), .rx_latency_valid_i(s_lat_v),
    .tx_cnt_o(s_tx_cnt), .rx_cnt_o(s_rx_cnt), .err_cnt_o(s_err_cnt), .lost_cnt_o(s_lost_cnt),
    .lat_cnt_o(s_lat_cnt), .lat_min_o(s_lat_min), .lat_max_o(s_lat_max), .lat_sum_o(s_lat_sum),
    .synced_o(s_synced));

  int total = 0, bad = 0;
  logic [DW-1:0] q[$];
  logic [7:0]    sq[$];
  logic [DW-1:0] exp_seq;
  logic [7:0]    s_seq;
  logic          saw;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [DW-1:0] w);
    m_rx_data = w; m_rx_valid = 1'b1; tick; m_rx_valid = 1'b0;
  endtask

  task automatic lat_in(input logic [LW-1:0] v);
    lat = v; lat_v = 1'b1; tick; lat_v = 1'b0;
  endtask

  task automatic tx_word(input string tag);
    logic [DW-1:0] e;
    q.push_back(exp_seq); exp_seq = exp_seq + 1;
    tick;
    chk({tag, "_valid"}, tx_valid, 1);
    e = q.pop_front();
    chk({tag, "_data"}, tx_data, e);
  endtask

  initial begin
    rst = 1; en = 0; clr = 0; txr = 8'hFF; rxr = 8'hFF; tx_dreq = 0; loop = 0;
    m_rx_valid = 0; m_rx_data = '0; rx_lost = 0; lat = '0; lat_v = 0;
    s_en = 0; s_dreq = 0; s_loop = 0; s_m_valid = 0; s_m_data = '0; s_lat = '0; s_lat_v = 0; s_lost = 0;
    exp_seq = '0; s_seq = '0;
    tick; tick;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_rx_dreq", rx_dreq, 0);
    chk("rst_synced", synced, 0);
    chk("rst_tx_cnt", tx_cnt, 0);
    chk("rst_lat_min", lat_min, {LW{1'b1}});
    chk("rst_lat_max", lat_max, 0);

    // Loopback at full rate
    rst = 0; en = 1; tx_dreq = 1; loop = 1;
    for (int i = 0; i < 1000; i++) tx_word("loop");
    tx_dreq = 0; tick; tick;
    chk("loop_rx_cnt", rx_cnt, 1000);
    chk("loop_tx_cnt", tx_cnt, 1000);
    chk("loop_err", err_cnt, 0);
    chk("loop_lost", lost_cnt, 0);
    chk("loop_synced", synced, 1);
    chk("loop_rx_dreq", rx_dreq, 1);

    // Injected sequence error
    loop = 0; en = 0; clr = 1; tick; en = 1; clr = 0;
    chk("clr_rx_cnt", rx_cnt, 0);
    chk("dis_synced", synced, 0);
    send(3); send(4); send(9);
    chk("inj_err", err_cnt, 1);
    chk("inj_synced", synced, 1);
    send(10);
    chk("inj_err_after", err_cnt, 1);
    chk("inj_rx_cnt", rx_cnt, 4);
    chk("inj_synced2", synced, 1);

    // Lost frame, then resync
    clr = 1; tick; clr = 0;
    rx_lost = 1; tick; rx_lost = 0;
    chk("lost_synced0", synced, 0);
    chk("lost_cnt", lost_cnt, 1);
    send(20);
    chk("lost_synced1", synced, 1);
    send(21);
    chk("lost_err", err_cnt, 0);
    chk("lost_rx_cnt", rx_cnt, 2);
    rx_lost = 1; m_rx_data = 50; m_rx_valid = 1; tick; rx_lost = 0; m_rx_valid = 0;
    chk("lostv_synced", synced, 1);
    chk("lostv_lost", lost_cnt, 2);
    chk("lostv_err", err_cnt, 0);
    send(51);
    chk("lostv_err2", err_cnt, 0);
    chk("lostv_rx_cnt", rx_cnt, 4);

    // Latency statistics and clear
    clr = 1; tick; clr = 0;
    chk("lat_min_init", lat_min, {LW{1'b1}});
    lat_in(100); lat_in(40); lat_in(300);
    chk("lat_min", lat_min, 40);
    chk("lat_max", lat_max, 300);
    chk("lat_sum", lat_sum, 440);
    chk("lat_cnt", lat_cnt, 3);
    clr = 1; tick; clr = 0;
    chk("clr_lat_min", lat_min, {LW{1'b1}});
    chk("clr_lat_max", lat_max, 0);
    chk("clr_lat_sum", lat_sum, 0);
    chk("clr_lat_cnt", lat_cnt, 0);
    chk("clr_rx_cnt2", rx_cnt, 0);
    chk("clr_lost", lost_cnt, 0);
    chk("clr_synced", synced, 1);
    clr = 1; lat = 7; lat_v = 1; tick; clr = 0; lat_v = 0;
    chk("clrwin_lat_cnt", lat_cnt, 0);
    chk("clrwin_lat_min", lat_min, {LW{1'b1}});

    // Zero TX rate, then reset mid-stream
    txr = 8'h00; tx_dreq = 1; saw = 0;
    repeat (200) begin tick; if (tx_valid) saw = 1; end
    chk("rate0_no_valid", saw, 0);
    txr = 8'hFF; loop = 1;
    for (int i = 0; i < 5; i++) tx_word("resume");
    rst = 1; tick;
    chk("mrst_tx_valid", tx_valid, 0);
    chk("mrst_tx_data", tx_data, 0);
    chk("mrst_rx_dreq", rx_dreq, 0);
    chk("mrst_synced", synced, 0);
    chk("mrst_rx_cnt", rx_cnt, 0);
    chk("mrst_tx_cnt", tx_cnt, 0);
    chk("mrst_lat_min", lat_min, {LW{1'b1}});
    rst = 0; q.delete(); exp_seq = '0;
    tx_word("post_rst0");
    tx_word("post_rst1");
    tx_dreq = 0; loop = 0; tick;

    // Narrow data path: wrap and saturation
    s_en = 1; s_dreq = 1; s_loop = 1;
    for (int i = 0; i < 300; i++) begin
      logic [7:0] e;
      sq.push_back(s_seq); s_seq = s_seq + 8'd1;
      tick;
      e = sq.pop_front();
      chk("wrap_data", s_tx_data, e);
    end
    s_dreq = 0; tick; tick;
    chk("wrap_err", s_err_cnt, 0);
    chk("wrap_rx_sat", s_rx_cnt, 15);
    chk("wrap_tx_sat", s_tx_cnt, 15);
    s_loop = 0; s_m_data = 8'd0; s_m_valid = 1;
    repeat (20) tick;
    s_m_valid = 0;
    chk("err_sat", s_err_cnt, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/streamer_traffic_checker.md
STREAMER_TRAFFIC_CHECKER -- requirements
Module: streamer_traffic_checker

Interface
REQ-001 SHALL have parameter g_data_width, default 64: record width of generated and checked data.
REQ-002 SHALL have parameter g_lat_width, default 28: latency input width, in clk_ref cycles.
REQ-003 SHALL have parameter g_cnt_width, default 32: width of every statistics counter.
REQ-004 SHALL have port clk_sys_i, in, 1: single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_i, in, 1: reset, synchronous, active-high.
REQ-006 SHALL have port cfg_enable_i, in, 1: 1 = generator and checker run.
REQ-007 SHALL have port cfg_clear_i, in, 1: 1-cycle pulse that clears statistics.
REQ-008 SHALL have ports cfg_tx_rate_i and cfg_rx_rate_i, in, 8 each: throttle thresholds.
REQ-009 SHALL have ports tx_data_o (out, g_data_width), tx_valid_o (out, 1) and tx_dreq_i (in, 1): streamer TX-side user interface.
REQ-010 SHALL have ports rx_data_i (in, g_data_width), rx_valid_i (in, 1), rx_lost_i (in, 1) and rx_dreq_o (out, 1): streamer RX-side user interface.
REQ-011 SHALL have ports rx_latency_i (in, g_lat_width) and rx_latency_valid_i (in, 1): per-frame latency report.
REQ-012 SHALL have ports tx_cnt_o, rx_cnt_o, err_cnt_o, lost_cnt_o and lat_cnt_o, out, g_cnt_width each: statistics counters.
REQ-013 SHALL have ports lat_min_o and lat_max_o (out, g_lat_width) and lat_sum_o (out, g_lat_width+16): latency statistics.
REQ-014 SHALL have port synced_o, out, 1: checker is locked to the sequence.

Function
REQ-015 SHALL use a 16-bit Fibonacci LFSR, taps 16,14,13,11, seeded 0xACE1 at reset, that advances every cycle regardless of enable.
REQ-016 SHALL compute tx_go = cfg_enable_i & tx_dreq_i & (cfg_tx_rate_i==8'hFF | lfsr[7:0] < cfg_tx_rate_i).
REQ-017 SHALL, in a cycle where tx_go=1, register tx_data_o <= tx_seq, set tx_valid_o <= 1 and increment tx_seq; otherwise it SHALL set tx_valid_o <= 0 and hold tx_data_o.
REQ-018 SHALL make tx_seq g_data_width wide, start at 0, and wrap from all-ones to 0 without error.
REQ-019 SHALL register rx_dreq_o <= cfg_enable_i & (cfg_rx_rate_i==8'hFF | lfsr[15:8] < cfg_rx_rate_i).
REQ-020 SHALL implement a checker FSM with states SYNC and TRACK.
REQ-021 SHALL, in SYNC on rx_valid_i, load expected <= rx_data_i+1 (modulo 2^g_data_width), increment rx_cnt, move to TRACK, and not increment err_cnt.
REQ-022 SHALL, in TRACK on rx_valid_i with rx_data_i==expected, increment rx_cnt and expected.
REQ-023 SHALL, in TRACK on rx_valid_i with rx_data_i!=expected, increment rx_cnt and err_cnt, set expected <= rx_data_i+1 and stay in TRACK.
REQ-024 SHALL, on rx_lost_i in any state, increment lost_cnt and enter SYNC; if rx_valid_i is high in the same cycle, that word SHALL be handled as in SYNC (REQ-021).
REQ-025 SHALL enter SYNC whenever cfg_enable_i=0.
REQ-026 SHALL drive synced_o = (state==TRACK), registered.
REQ-027 SHALL, on rx_latency_valid_i, increment lat_cnt, add rx_latency_i to lat_sum, set lat_min <= min(lat_min, rx_latency_i) and set lat_max <= max(lat_max, rx_latency_i).
REQ-028 SHALL make all counters and lat_sum saturate at all-ones and never wrap.
REQ-029 SHALL initialise lat_min to all-ones and lat_max to 0; lat_min SHALL stay all-ones until the first sample.
REQ-030 SHALL make cfg_clear_i reset all counters, lat_sum, lat_min and lat_max to their reset values; when cfg_clear_i coincides with an event, the clear SHALL win and the event SHALL be dropped.
REQ-031 SHALL not let cfg_clear_i affect tx_seq, expected, the FSM state or the LFSR.
REQ-032 SHALL make every statistics output a register updated one cycle after its event.

Reset
REQ-033 SHALL, while rst_i=1, hold tx_valid_o=0, rx_dreq_o=0, tx_data_o=0, tx_seq=0, expected=0, state=SYNC, synced_o=0, all counters=0, lat_sum=0, lat_min=all-ones, lat_max=0, lfsr=0xACE1.
REQ-034 SHALL, when rst_i is asserted mid-stream, abort the stream within one cycle, and after release the first generated word SHALL be 0.

Verification
REQ-035 SHALL be verified by this scenario: loopback with rates 0xFF, tx_dreq_i=1, 1000 cycles -> tx_data_o values are 0,1,2,... with no gaps; err_cnt=0, lost_cnt=0, rx_cnt equals the words delivered.
REQ-036 SHALL be verified by this scenario: inject word 5 replaced by 9 -> err_cnt=1; 10 is accepted without further error; synced_o stays 1.
REQ-037 SHALL be verified by this scenario: rx_lost_i pulse, then words 20,21 -> lost_cnt=1, err_cnt=0, synced_o=0 for one cycle, then 1.
REQ-038 SHALL be verified by this scenario: latencies 100, 40, 300 -> lat_min=40, lat_max=300, lat_sum=440, lat_cnt=3; then cfg_clear_i -> lat_min all-ones and all other statistics 0.
REQ-039 SHALL be verified by this scenario: g_data_width=8, run past 255 -> tx_data_o wraps 255->0 and err_cnt=0; with g_cnt_width=4, 20 errors -> err_cnt=15.
REQ-040 SHALL be verified by this scenario: cfg_tx_rate_i=0 -> tx_valid_o never asserts; rst_i pulse mid-run -> REQ-033 values are present the cycle after.
